// File: rtl/ipe_cfg_master_if.sv
// Bus-side signals of ipe_cfg_master: backbone request/grant plus the
// peripheral word-access port. The master drives the request and access fields.
interface ipe_cfg_master_if;
    logic        bus_req;
    logic        bus_gnt;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;

    modport master (
        output bus_req, per_addr, per_din, per_en, per_we,
        input  bus_gnt, per_dout
    );

    modport slave (
        input  bus_req, per_addr, per_din, per_en, per_we,
        output bus_gnt, per_dout
    );
endinterface

// File: rtl/ipe_cfg_master.sv
// Programs the IPE segment bounds and control word over the peripheral bus.
// Optional readback verification is enabled by defining IPE_CFG_READBACK_EN.
module ipe_cfg_master #(
    parameter logic [14:0] BASE_ADDR = 15'h05A8
) (
    input  logic             mclk,
    input  logic             puc_rst_n,
    input  logic             cfg_start,
    input  logic [15:0]      cfg_segb1,
    input  logic [15:0]      cfg_segb2,
    input  logic [15:0]      cfg_ctrl,
    output logic             cfg_busy,
    output logic             cfg_done,
    output logic [1:0]       cfg_err,
    ipe_cfg_master_if.master bus
);

    localparam logic [14:0] IPC0_BYTE  = BASE_ADDR + 15'd2;
    localparam logic [14:0] SEGB2_BYTE = BASE_ADDR + 15'd4;
    localparam logic [14:0] SEGB1_BYTE = BASE_ADDR + 15'd6;
    localparam logic [13:0] IPC0_WA    = IPC0_BYTE[14:1];
    localparam logic [13:0] SEGB2_WA   = SEGB2_BYTE[14:1];
    localparam logic [13:0] SEGB1_WA   = SEGB1_BYTE[14:1];

    localparam logic [1:0] ERR_OK       = 2'd0;
    localparam logic [1:0] ERR_LOCKED   = 2'd1;
    localparam logic [1:0] ERR_MISMATCH = 2'd2;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        CHK_LOCK = 4'd1,
        WR_B1    = 4'd2,
        WR_B2    = 4'd3,
        WR_C0    = 4'd4,
        RD_B1    = 4'd5,
        RD_B2    = 4'd6,
        RD_C0    = 4'd7,
        DONE     = 4'd8
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] segb1_q, segb1_d;
    logic [15:0] segb2_q, segb2_d;
    logic [15:0] ctrl_q,  ctrl_d;
    logic [1:0]  err_q,   err_d;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process evaluation order.
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            state_q <= IDLE;
            segb1_q <= '0;
            segb2_q <= '0;
            ctrl_q  <= '0;
            err_q   <= ERR_OK;
        end else begin
            state_q <= state_d;
            segb1_q <= segb1_d;
            segb2_q <= segb2_d;
            ctrl_q  <= ctrl_d;
            err_q   <= err_d;
        end
    end

    // Bus states advance only on a granted cycle; a denied grant is a stall.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case leaves it unassigned and no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE:     if (cfg_start)   state_d = CHK_LOCK;
            CHK_LOCK: if (bus.bus_gnt) state_d = bus.per_dout[7] ? DONE : WR_B1;
            WR_B1:    if (bus.bus_gnt) state_d = WR_B2;
            WR_B2:    if (bus.bus_gnt) state_d = WR_C0;
`ifdef IPE_CFG_READBACK_EN
            WR_C0:    if (bus.bus_gnt) state_d = RD_B1;
            RD_B1:    if (bus.bus_gnt) state_d = RD_B2;
            RD_B2:    if (bus.bus_gnt) state_d = RD_C0;
            RD_C0:    if (bus.bus_gnt) state_d = DONE;
`else
            WR_C0:    if (bus.bus_gnt) state_d = DONE;
`endif
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        segb1_d = segb1_q;
        segb2_d = segb2_q;
        ctrl_d  = ctrl_q;
        err_d   = err_q;
        if (state_q == IDLE && cfg_start) begin
            segb1_d = cfg_segb1;
            segb2_d = cfg_segb2;
            ctrl_d  = cfg_ctrl;
            err_d   = ERR_OK;
        end
        if (state_q == CHK_LOCK && bus.bus_gnt && bus.per_dout[7]) begin
            err_d = ERR_LOCKED;
        end
`ifdef IPE_CFG_READBACK_EN
        // Segment registers only implement bits [12:0]; the rest read as zero.
        if (bus.bus_gnt) begin
            case (state_q)
                RD_B1: if (bus.per_dout != {3'b000, segb1_q[12:0]}) err_d = ERR_MISMATCH;
                RD_B2: if (bus.per_dout != {3'b000, segb2_q[12:0]}) err_d = ERR_MISMATCH;
                RD_C0: if (bus.per_dout != ctrl_q)                  err_d = ERR_MISMATCH;
                default: ;
            endcase
        end
`endif
    end

    always_comb begin
        bus.bus_req  = 1'b0;
        bus.per_en   = 1'b0;
        bus.per_we   = 2'b00;
        bus.per_addr = '0;
        bus.per_din  = '0;
        cfg_busy     = (state_q != IDLE);
        cfg_done     = (state_q == DONE);
        cfg_err      = err_q;
        case (state_q)
            CHK_LOCK: begin
                bus.bus_req  = 1'b1;
                bus.per_en   = bus.bus_gnt;
                bus.per_addr = IPC0_WA;
            end
            // IPC0 goes last so a lock bit in ctrl only lands once bounds are set.
            WR_B1: begin
                bus.bus_req  = 1'b1;
                bus.per_en   = bus.bus_gnt;
                bus.per_we   = 2'b11;
                bus.per_addr = SEGB1_WA;
                bus.per_din  = segb1_q;
            end
            WR_B2: begin
                bus.bus_req  = 1'b1;
                bus.per_en   = bus.bus_gnt;
                bus.per_we   = 2'b11;
                bus.per_addr = SEGB2_WA;
                bus.per_din  = segb2_q;
            end
            WR_C0: begin
                bus.bus_req  = 1'b1;
                bus.per_en   = bus.bus_gnt;
                bus.per_we   = 2'b11;
                bus.per_addr = IPC0_WA;
                bus.per_din  = ctrl_q;
            end
`ifdef IPE_CFG_READBACK_EN
            RD_B1: begin
                bus.bus_req  = 1'b1;
                bus.per_en   = bus.bus_gnt;
                bus.per_addr = SEGB1_WA;
            end
            RD_B2: begin
                bus.bus_req  = 1'b1;
                bus.per_en   = bus.bus_gnt;
                bus.per_addr = SEGB2_WA;
            end
            RD_C0: begin
                bus.bus_req  = 1'b1;
                bus.per_en   = bus.bus_gnt;
                bus.per_addr = IPC0_WA;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ipe_cfg_master.sv
// Self-checking bench for ipe_cfg_master: register-file responder, write/read
// log, and a transaction-level model of the expected writes, latency and error.
module tb_ipe_cfg_master;

    localparam logic [13:0] A_IPC0  = 14'h2D5;
    localparam logic [13:0] A_SEGB2 = 14'h2D6;
    localparam logic [13:0] A_SEGB1 = 14'h2D7;
`ifdef IPE_CFG_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic        mclk      = 1'b0;
    logic        puc_rst_n = 1'b0;
    logic        cfg_start = 1'b0;
    logic [15:0] cfg_segb1 = '0;
    logic [15:0] cfg_segb2 = '0;
    logic [15:0] cfg_ctrl  = '0;
    logic        cfg_busy;
    logic        cfg_done;
    logic [1:0]  cfg_err;

    ipe_cfg_master_if bus ();

    ipe_cfg_master #(.BASE_ADDR(15'h05A8)) dut (
        .mclk      (mclk),
        .puc_rst_n (puc_rst_n),
        .cfg_start (cfg_start),
        .cfg_segb1 (cfg_segb1),
        .cfg_segb2 (cfg_segb2),
        .cfg_ctrl  (cfg_ctrl),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .bus       (bus)
    );

    always #5 mclk = ~mclk;

    // Responder: segment registers hold 13 bits; lock_force reports IPC0 as
    // locked, fault_b2 makes SEGB2 read back one less than stored.
    logic [15:0] r_ipc0  = '0;
    logic [15:0] r_segb1 = '0;
    logic [15:0] r_segb2 = '0;
    logic        lock_force = 1'b0;
    logic        fault_b2   = 1'b0;

    always_comb begin
        bus.per_dout = 16'h0000;
        case (bus.per_addr)
            A_IPC0:  bus.per_dout = r_ipc0 | (lock_force ? 16'h00C0 : 16'h0000);
            A_SEGB2: bus.per_dout = r_segb2 - (fault_b2 ? 16'd1 : 16'd0);
            A_SEGB1: bus.per_dout = r_segb1;
            default: bus.per_dout = 16'h0000;
        endcase
    end

    logic [29:0] wr_q[$];
    int          rd_cnt = 0;
    int          viol   = 0;

    always @(posedge mclk) begin
        if (bus.per_en && bus.per_we == 2'b11) begin
            wr_q.push_back({bus.per_addr, bus.per_din});
            case (bus.per_addr)
                A_IPC0:  r_ipc0  <= bus.per_din;
                A_SEGB2: r_segb2 <= bus.per_din & 16'h1FFF;
                A_SEGB1: r_segb1 <= bus.per_din & 16'h1FFF;
                default: ;
            endcase
        end
        if (bus.per_en && bus.per_we == 2'b00) rd_cnt <= rd_cnt + 1;
        if ((bus.bus_req && bus.per_en !== bus.bus_gnt) ||
            (!bus.bus_req && (bus.per_en || bus.per_we != 2'b00 ||
                              bus.per_addr != 14'h0 || bus.per_din != 16'h0)) ||
            (bus.per_en && bus.per_we != 2'b00 && bus.per_we != 2'b11) ||
            (bus.per_we == 2'b00 && bus.per_din != 16'h0))
            viol <= viol + 1;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One configuration run. Stall window [stall_at, stall_at+stall_len)
    // denies the grant; busy_start_at pulses a stray start mid-sequence.
    task automatic run_txn(input logic [15:0] s1, input logic [15:0] s2, input logic [15:0] c,
                           input int stall_at, input int stall_len, input bit rnd_gnt,
                           input int busy_start_at);
        logic [29:0] exp_w[$];
        int          need, exp_reads, wbase, rbase, vbase, n, granted;
        logic [1:0]  exp_err;
        bit          g, gp, early;
        logic [13:0] pa;
        logic [15:0] pd;

        if (lock_force) begin
            need      = 1;
            exp_reads = 1;
            exp_err   = 2'd1;
        end else begin
            exp_w.push_back({A_SEGB1, s1});
            exp_w.push_back({A_SEGB2, s2});
            exp_w.push_back({A_IPC0, c});
            need      = RB ? 7 : 4;
            exp_reads = RB ? 4 : 1;
            exp_err   = (RB && fault_b2) ? 2'd2 : 2'd0;
        end
        wbase = wr_q.size();
        rbase = rd_cnt;
        vbase = viol;

        @(negedge mclk);
        cfg_start   = 1'b1;
        cfg_segb1   = s1;
        cfg_segb2   = s2;
        cfg_ctrl    = c;
        bus.bus_gnt = 1'($urandom_range(0, 1));
        @(negedge mclk);
        cfg_segb1 = ~s1;
        cfg_segb2 = ~s2;
        cfg_ctrl  = ~c;

        n = 1; granted = 0; early = 1'b0; gp = 1'b1; pa = '0; pd = '0;
        while (granted < need && n < 400) begin
            if (n >= stall_at && n < stall_at + stall_len) g = 1'b0;
            else if (rnd_gnt)                             g = ($urandom_range(0, 3) != 0);
            else                                          g = 1'b1;
            cfg_start = (n == busy_start_at);
            if (n == busy_start_at) begin
                cfg_segb1 = 16'hFFFF;
                cfg_segb2 = 16'hFFFF;
                cfg_ctrl  = 16'hFFFF;
            end
            bus.bus_gnt = g;
            #1;
            if (n == 1) check("err_clr_on_start", cfg_err, 2'd0);
            if (cfg_done || !cfg_busy || !bus.bus_req) early = 1'b1;
            if (!gp) check("stall_hold", {bus.per_addr, bus.per_din}, {pa, pd});
            pa = bus.per_addr;
            pd = bus.per_din;
            gp = g;
            if (g) granted++;
            @(negedge mclk);
            n++;
        end
        cfg_start   = 1'b0;
        bus.bus_gnt = 1'($urandom_range(0, 1));
        #1;
        check("no_early_done", early, 1'b0);
        check("done_pulse", cfg_done, 1'b1);
        check("busy_at_done", cfg_busy, 1'b1);
        check("err_at_done", cfg_err, exp_err);

        @(negedge mclk);
        #1;
        check("done_one_cycle", cfg_done, 1'b0);
        check("idle_not_busy", cfg_busy, 1'b0);
        check("err_held", cfg_err, exp_err);
        check("write_count", wr_q.size() - wbase, exp_w.size());
        for (int i = 0; i < exp_w.size(); i++)
            if (wbase + i < wr_q.size()) check("write_order", wr_q[wbase + i], exp_w[i]);
        check("read_count", rd_cnt - rbase, exp_reads);
        check("bus_protocol", viol - vbase, 0);
    endtask

    initial begin
        int          wbase;
        logic [15:0] s1, s2, c;
        bus.bus_gnt = 1'b0;

        // Reset state
        #12;
        check("rst_busy", cfg_busy, 1'b0);
        check("rst_done", cfg_done, 1'b0);
        check("rst_err", cfg_err, 2'd0);
        check("rst_bus", {bus.bus_req, bus.per_en, bus.per_we, bus.per_addr, bus.per_din}, 32'h0);
        @(negedge mclk);
        puc_rst_n = 1'b1;

        // Clean programming sequence
        run_txn(16'h0800, 16'h0C00, 16'h0040, 0, 0, 1'b0, -1);

        // Locked peripheral aborts without writes
        lock_force = 1'b1;
        run_txn(16'h0800, 16'h0C00, 16'h0040, 0, 0, 1'b0, -1);
        lock_force = 1'b0;

        // SEGB2 readback disagrees; error must stay until the next start
        fault_b2 = 1'b1;
        run_txn(16'h0800, 16'h0C00, 16'h0040, 0, 0, 1'b0, -1);
        fault_b2 = 1'b0;
        repeat (3) @(negedge mclk);
        #1;
        check("err_sticky", cfg_err, RB ? 2'd2 : 2'd0);

        // Three denied grants during WR_B2, then a stray start while busy
        run_txn(16'h0123, 16'h0456, 16'h0011, 3, 3, 1'b0, -1);
        run_txn(16'hE1F0, 16'h3A5C, 16'h0102, 0, 0, 1'b0, 2);

        // Reset pulse in WR_B2
        wbase = wr_q.size();
        @(negedge mclk);
        cfg_start = 1'b1; cfg_segb1 = 16'h0AAA; cfg_segb2 = 16'h0555; cfg_ctrl = 16'h0003;
        bus.bus_gnt = 1'b1;
        @(negedge mclk);
        cfg_start = 1'b0;
        repeat (2) @(negedge mclk);
        #1;
        check("pre_rst_in_wr_b2", {bus.per_addr, bus.per_din}, {A_SEGB2, 16'h0555});
        puc_rst_n = 1'b0;
        #1;
        check("rst_mid_busy", cfg_busy, 1'b0);
        check("rst_mid_bus", {bus.bus_req, bus.per_en, bus.per_we, bus.per_addr, bus.per_din}, 32'h0);
        @(negedge mclk);
        puc_rst_n = 1'b1;
        repeat (6) @(negedge mclk);
        #1;
        check("post_rst_idle", cfg_busy, 1'b0);
        check("post_rst_writes", wr_q.size() - wbase, 1);

        // Randomized runs against the transaction model
        repeat (24) begin
            s1 = 16'($urandom_range(0, 65535));
            s2 = 16'($urandom_range(0, 65535));
            c  = 16'($urandom_range(0, 65535)) & 16'hFF7F;
            lock_force = ($urandom_range(0, 4) == 0);
            fault_b2   = ($urandom_range(0, 3) == 0);
            run_txn(s1, s2, c, $urandom_range(1, 6), $urandom_range(0, 2), 1'b1,
                    ($urandom_range(0, 3) == 0) ? $urandom_range(2, 5) : -1);
            repeat ($urandom_range(0, 2)) @(negedge mclk);
        end
        lock_force = 1'b0;
        fault_b2   = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ipe_cfg_master.md
IPE_CFG_MASTER -- requirements
Module: ipe_cfg_master

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 15'h05A8, byte base address of the IPE register peripheral.
REQ-002 SHALL have ports: mclk in 1 main clock; puc_rst_n in 1 asynchronous active-low reset.
REQ-003 SHALL have ports: cfg_start in 1 start pulse; cfg_segb1 in 16, cfg_segb2 in 16, cfg_ctrl in 16 requested values; cfg_busy out 1; cfg_done out 1; cfg_err out 2 (0 ok, 1 locked, 2 mismatch).
REQ-004 SHALL have ports: bus_req out 1; bus_gnt in 1 grant from the memory backbone.
REQ-005 SHALL have ports: per_addr out 14 word address; per_din out 16 write data; per_en out 1; per_we out 2; per_dout in 16 read data from the responder, combinational in the cycle of per_en.

Function
REQ-006 SHALL use word addresses: IPC0 = (BASE_ADDR+2)>>1, SEGB2 = (BASE_ADDR+4)>>1, SEGB1 = (BASE_ADDR+6)>>1 (defaults 0x2D5, 0x2D6, 0x2D7).
REQ-007 SHALL use FSM states IDLE, CHK_LOCK, WR_B1, WR_B2, WR_C0, RD_B1, RD_B2, RD_C0, DONE.
REQ-008 IDLE: cfg_start=1 SHALL latch cfg_segb1/segb2/ctrl, clear cfg_err, and go to CHK_LOCK; cfg_start in any other state SHALL be ignored.
REQ-009 cfg_busy SHALL be 1 in every state except IDLE; bus_req SHALL be 1 in CHK_LOCK through RD_C0.
REQ-010 In bus states, per_en SHALL equal bus_gnt; with bus_gnt=0, state and outputs other than per_en SHALL hold (stall, no transaction).
REQ-011 CHK_LOCK: read IPC0 (per_we=0); on a granted edge, per_dout[7]=1 SHALL go to DONE with cfg_err=1 and issue no writes; otherwise go to WR_B1.
REQ-012 WR_B1, WR_B2, WR_C0: SHALL write latched segb1, segb2, ctrl to SEGB1, SEGB2, IPC0 in that order, per_we=2'b11, one granted cycle each; IPC0 SHALL be written last so a lock bit in ctrl takes effect only after the segment bounds are set.
REQ-013 RD_B1, RD_B2, RD_C0: SHALL read back each register (per_we=0), comparing SEGB1/SEGB2 against {3'b000, latched[12:0]} and IPC0 against latched ctrl; any mismatch SHALL set cfg_err=2 (sticky until the next start); after RD_C0, go to DONE.
REQ-014 DONE: cfg_done SHALL be 1 for exactly one cycle, then IDLE; cfg_err SHALL hold until the next accepted start.
REQ-015 Outside bus states, per_en=0, per_we=0, per_addr=0, per_din=0; per_din SHALL be 0 during reads.
REQ-016 With bus_gnt held 1 and start sampled at edge t: CHK_LOCK at t+1, DONE (cfg_done=1) at t+8; locked-abort DONE at t+2.

Reset
REQ-017 puc_rst_n=0 SHALL asynchronously force IDLE, latched values 0, cfg_err=0, and all outputs 0, including mid-sequence; no partial transaction SHALL resume after reset release.

Configuration
REQ-018 Macro IPE_CFG_READBACK_EN defined: readback states RD_B1..RD_C0 SHALL be present per REQ-013.
REQ-019 Macro IPE_CFG_READBACK_EN undefined: WR_C0 SHALL go directly to DONE (DONE at t+5), and cfg_err SHALL never be 2.

Verification
REQ-020 Lock clear, gnt=1, start with segb1=0x0800, segb2=0x0C00, ctrl=0x0040 -> writes 0x2D7=0x0800, 0x2D6=0x0C00, 0x2D5=0x0040 in order; cfg_done at t+8; cfg_err=0.
REQ-021 Responder IPC0 reads 0x00C0 (locked), start -> no per_we activity; cfg_done at t+2; cfg_err=1.
REQ-022 Responder SEGB2 read returns 0x0BFF after writing 0x0C00 -> cfg_err=2 at DONE; held until next start.
REQ-023 bus_gnt=0 for 3 cycles during WR_B2 -> per_en=0, address/data held; sequence completes 3 cycles late with a correct write order.
REQ-024 puc_rst_n pulsed low during WR_B2 -> outputs 0 immediately; after release, IDLE, no further writes until a new start; a start arriving while busy is ignored.
REQ-025 Build without IPE_CFG_READBACK_EN; mismatching responder -> cfg_done at t+5, cfg_err=0, no read cycles after CHK_LOCK.
